// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl: read-side sequencer for the interleaved window RAM.
// Walks every valid window origin of a T_WIDTH x T_WIDTH tile in raster order
// at STRIDE, issues one read per cycle, and delays the issue information by the
// RAM's two-cycle read latency so win_* lines up with doutb.
module window_scan_ctrl #(
  parameter  int I_WIDTH = 5,
  parameter  int T_WIDTH = 32,
  parameter  int STRIDE  = 1,
  localparam int T_LOG   = $clog2(T_WIDTH),
  localparam int N_POS   = (T_WIDTH - I_WIDTH) / STRIDE + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic [T_LOG-1:0] addrb_y,
  output logic [T_LOG-1:0] addrb_x,
  output logic             re,
  output logic             win_valid,
  output logic [T_LOG-1:0] win_y,
  output logic [T_LOG-1:0] win_x,
  output logic             win_last
);

  // A stride that does not land exactly on the last origin cannot be scanned.
  generate
    if ((T_WIDTH - I_WIDTH) % STRIDE != 0) begin : g_bad_stride
      $error("window_scan_ctrl: (T_WIDTH-I_WIDTH) must be a multiple of STRIDE");
    end
  endgenerate

  // Last valid origin and the stride, both one bit wider than an address so the
  // advanced value never overflows when T_WIDTH is a power of two.
  localparam logic [T_LOG:0] LIM_W  = (T_LOG+1)'((N_POS - 1) * STRIDE);
  localparam logic [T_LOG:0] STEP_W = (T_LOG+1)'(STRIDE);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic             issued;
    logic [T_LOG-1:0] y;
    logic [T_LOG-1:0] x;
    logic             last;
  } issue_t;

  state_t           state_reg, state_next;
  logic [T_LOG-1:0] y_reg, y_next;
  logic [T_LOG-1:0] x_reg, x_next;
  logic [1:0]       drain_reg, drain_next;
  logic             busy_reg, done_reg;
  logic [T_LOG:0]   x_wide, y_wide;
  logic             x_wrap, y_wrap;
  logic             issue_last;
  issue_t           issue_in;
  issue_t           pipe_d   [0:1];
  issue_t           pipe_reg [0:1];

  // Addresses come straight from the origin counters; doutb stays stable while held.
  assign addrb_y = y_reg;
  assign addrb_x = x_reg;

  // Origins are always multiples of STRIDE, so stepping past the last origin
  // is equivalent to sitting on it.
  assign x_wide = {1'b0, x_reg} + STEP_W;
  assign y_wide = {1'b0, y_reg} + STEP_W;
  assign x_wrap = (x_wide > LIM_W);
  assign y_wrap = (y_wide > LIM_W);

  // State, counter and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      y_reg     <= '0;
      x_reg     <= '0;
      drain_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
      x_reg     <= x_next;
      drain_reg <= drain_next;
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_next == DONE);
    end
  end

  // Next-state, raster-order counter advance and read enable.
  always_comb begin
    state_next = state_reg;
    y_next     = y_reg;
    x_next     = x_reg;
    drain_next = drain_reg;
    re         = 1'b0;
    issue_last = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SCAN;
          y_next     = '0;
          x_next     = '0;
        end
      end
      SCAN: begin
        re = !stall;
        if (!stall) begin
          if (x_wrap) begin
            if (y_wrap) begin
              // Final origin issued: hold y/x and wait for the reads in flight.
              issue_last = 1'b1;
              state_next = DRAIN;
              drain_next = 2'd2;
            end else begin
              x_next = '0;
              y_next = y_wide[T_LOG-1:0];
            end
          end else begin
            x_next = x_wide[T_LOG-1:0];
          end
        end
      end
      DRAIN: begin
        drain_next = drain_reg - 2'd1;
        if (drain_reg == 2'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Describe the read issued this cycle; empty entries when nothing is issued.
  always_comb begin
    issue_in = '0;
    if (re) begin
      issue_in.issued = 1'b1;
      issue_in.y      = y_reg;
      issue_in.x      = x_reg;
      issue_in.last   = issue_last;
    end
  end

  // Two-stage shift matching the RAM's array read plus doutb register.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_d[gi] = issue_in;
      end else begin : g_chain
        assign pipe_d[gi] = pipe_reg[gi-1];
      end

      // One latency stage of the issue record.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_reg[gi] <= '0;
        end else begin
          pipe_reg[gi] <= pipe_d[gi];
        end
      end
    end
  endgenerate

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign win_valid = pipe_reg[1].issued;
  assign win_y     = pipe_reg[1].y;
  assign win_x     = pipe_reg[1].x;
  assign win_last  = pipe_reg[1].last;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb_window_scan_ctrl: two instances (STRIDE 1 and STRIDE 3) checked every
// cycle against a window-index model, plus literal timing expectations.
module tb_window_scan_ctrl;

  localparam int TL = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start0, start1, stall0;
  logic          busy_s  [2];
  logic          done_s  [2];
  logic          re_s    [2];
  logic          wv_s    [2];
  logic          wl_s    [2];
  logic [TL-1:0] ay_s    [2];
  logic [TL-1:0] ax_s    [2];
  logic [TL-1:0] wy_s    [2];
  logic [TL-1:0] wx_s    [2];

  window_scan_ctrl #(.I_WIDTH(5), .T_WIDTH(32), .STRIDE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stall(stall0),
    .busy(busy_s[0]), .done(done_s[0]), .addrb_y(ay_s[0]), .addrb_x(ax_s[0]),
    .re(re_s[0]), .win_valid(wv_s[0]), .win_y(wy_s[0]), .win_x(wx_s[0]),
    .win_last(wl_s[0])
  );

  window_scan_ctrl #(.I_WIDTH(5), .T_WIDTH(32), .STRIDE(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stall(1'b0),
    .busy(busy_s[1]), .done(done_s[1]), .addrb_y(ay_s[1]), .addrb_x(ax_s[1]),
    .re(re_s[1]), .win_valid(wv_s[1]), .win_y(wy_s[1]), .win_x(wx_s[1]),
    .win_last(wl_s[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: a scan is a list of N*N window indices issued on non-stalled cycles.
  bit m_scan [2];
  int m_idx  [2];
  int m_last [2];      // cycle of the final issue
  int iss    [2][8];   // window index issued in cycle c (ring), -1 for none

  // Observed per-scan statistics for the literal checks.
  int st_cnt [2], st_first_re [2], st_lastwin [2], st_lasty [2], st_lastx [2];
  int st_nlast [2], st_done [2];
  bit done_seen [2];
  int st_w10, st_w11;

  function automatic int npos(input int k);
    return (k == 0) ? 28 : 10;
  endfunction

  function automatic int strd(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input int k, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0d, expected %0d at cycle %0d", k, name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats(input int k);
    st_cnt[k] = 0; st_first_re[k] = -1; st_lastwin[k] = -1;
    st_lasty[k] = -1; st_lastx[k] = -1; st_nlast[k] = 0; st_done[k] = -1;
    done_seen[k] = 1'b0;
    if (k == 0) begin st_w10 = -1; st_w11 = -1; end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_scan[k] = 1'b0;
      m_idx[k]  = 0;
      m_last[k] = -100;
      for (int j = 0; j < 8; j++) iss[k][j] = -1;
    end
  endtask

  // Per-cycle compare of both instances against the model, then model advance.
  task automatic compare_cycle();
    int  c, n, wi, e_y, e_x;
    bit  e_busy, e_done, e_re, e_wv, st, sr;
    c = cyc;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        chk(k, "rst_ctrl", int'({busy_s[k], done_s[k], re_s[k], wv_s[k], wl_s[k]}), 0);
        chk(k, "rst_addr", int'(ay_s[k] | ax_s[k] | wy_s[k] | wx_s[k]), 0);
      end
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      n      = npos(k);
      st     = (k == 0) ? stall0 : 1'b0;
      sr     = (k == 0) ? start0 : start1;
      e_busy = m_scan[k] || (c > m_last[k] && c <= m_last[k] + 3);
      e_done = (c == m_last[k] + 3);
      e_re   = m_scan[k] && !st;
      wi     = iss[k][(c - 2) & 7];
      e_wv   = (wi >= 0);
      chk(k, "busy", int'(busy_s[k]), int'(e_busy));
      chk(k, "done", int'(done_s[k]), int'(e_done));
      chk(k, "re", int'(re_s[k]), int'(e_re));
      if (e_re) begin
        chk(k, "addrb_y", int'(ay_s[k]), (m_idx[k] / n) * strd(k));
        chk(k, "addrb_x", int'(ax_s[k]), (m_idx[k] % n) * strd(k));
      end
      chk(k, "win_valid", int'(wv_s[k]), int'(e_wv));
      if (e_wv) begin
        e_y = (wi / n) * strd(k);
        e_x = (wi % n) * strd(k);
        chk(k, "win_y", int'(wy_s[k]), e_y);
        chk(k, "win_x", int'(wx_s[k]), e_x);
        chk(k, "win_last", int'(wl_s[k]), int'(wi == n * n - 1));
      end else begin
        chk(k, "win_last_idle", int'(wl_s[k]), 0);
      end
      // statistics from the DUT's own outputs
      if (re_s[k] && st_first_re[k] < 0) st_first_re[k] = c;
      if (wv_s[k]) begin
        st_cnt[k]++;
        st_lastwin[k] = c;
        if (k == 0 && wy_s[k] == 0 && wx_s[k] == 10) st_w10 = c;
        if (k == 0 && wy_s[k] == 0 && wx_s[k] == 11) st_w11 = c;
      end
      if (wl_s[k]) begin
        st_nlast[k]++;
        st_lasty[k] = int'(wy_s[k]);
        st_lastx[k] = int'(wx_s[k]);
      end
      if (done_s[k]) begin st_done[k] = c; done_seen[k] = 1'b1; end
      // advance the model into the next cycle
      iss[k][c & 7] = e_re ? m_idx[k] : -1;
      if (e_re) begin
        if (m_idx[k] == n * n - 1) begin
          m_scan[k] = 1'b0;
          m_last[k] = c;
        end
        m_idx[k]++;
      end else if (!e_busy && sr) begin
        m_scan[k] = 1'b1;
        m_idx[k]  = 0;
        clear_stats(k);
      end
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) run_cycle();
  endtask

  task automatic wait_done(input int k, input int budget);
    for (int i = 0; i < budget && !done_seen[k]; i++) run_cycle();
    chk(k, "done_within_budget", int'(done_seen[k]), 1);
  endtask

  int s, s2, s3, s4;

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; stall0 = 1'b0;
    model_reset();
    clear_stats(0); clear_stats(1);
    repeat (3) run_cycle();
    rst_n = 1'b1;
    run_cycle();

    // Scan A: both strides from one start; stray starts while busy and in DONE.
    s = cyc; start0 = 1'b1; start1 = 1'b1;
    run_cycle();
    start0 = 1'b0; start1 = 1'b0;
    run_until(s + 300);
    start0 = 1'b1;
    run_cycle();
    start0 = 1'b0;
    run_until(s + 787);
    start0 = 1'b1;                 // DONE cycle: must be ignored
    run_cycle();
    chk(0, "A_count", st_cnt[0], 784);
    chk(0, "A_first_re", st_first_re[0], s + 1);
    chk(0, "A_last_win_cycle", st_lastwin[0], s + 786);
    chk(0, "A_last_y", st_lasty[0], 27);
    chk(0, "A_last_x", st_lastx[0], 27);
    chk(0, "A_last_pulses", st_nlast[0], 1);
    chk(0, "A_done_cycle", st_done[0], s + 787);
    chk(1, "S3_count", st_cnt[1], 100);
    chk(1, "S3_last_y", st_lasty[1], 27);
    chk(1, "S3_last_x", st_lastx[1], 27);
    chk(1, "S3_done_cycle", st_done[1], s + 103);

    // Scan B: start in the cycle after DONE, 5 stall cycles after issuing (0,10).
    s2 = cyc;                      // start0 still high here
    run_cycle();
    start0 = 1'b0;
    run_until(s2 + 12);
    stall0 = 1'b1;
    repeat (5) run_cycle();
    stall0 = 1'b0;
    wait_done(0, 1200);
    chk(0, "B_first_re", st_first_re[0], s2 + 1);
    chk(0, "B_w10_cycle", st_w10, s2 + 13);
    chk(0, "B_w11_gap", st_w11 - st_w10, 6);
    chk(0, "B_count", st_cnt[0], 784);
    chk(0, "B_done_cycle", st_done[0], s2 + 792);
    repeat (2) run_cycle();

    // Scan C: reset in the middle, then a full fresh scan.
    s3 = cyc; start0 = 1'b1;
    run_cycle();
    start0 = 1'b0;
    run_until(s3 + 400);
    rst_n = 1'b0;
    run_cycle();
    chk(0, "C_busy_in_reset", int'(busy_s[0]), 0);
    run_cycle();
    rst_n = 1'b1;
    repeat (3) run_cycle();
    s4 = cyc; start0 = 1'b1;
    run_cycle();
    start0 = 1'b0;
    wait_done(0, 1200);
    chk(0, "C_count", st_cnt[0], 784);
    chk(0, "C_done_cycle", st_done[0], s4 + 787);
    repeat (3) run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
